disp_capture: RTL and testbench

DISP_CAPTURE -- requirements
Module: disp_capture

---
 rtl/disp_capture.sv | 197 +++++++++++++++++++
 tb/tb_disp_capture.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/disp_capture.sv
// disp_capture: samples a multiplexed 7-segment display bus and
// rebuilds complete BCD frames once every digit has settled.
module disp_capture #(
  parameter int SETTLE = 4,
  parameter int NDIG   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  an,
  input  logic [7:0]  dec_ddp,
  output logic [31:0] digits,
  output logic [7:0]  dp_mask,
  output logic [7:0]  blank_mask,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        an_err
);

  typedef enum logic [1:0] {
    S_WAIT,
    S_SETTLE,
    S_HOLD
  } state_t;

  localparam logic [7:0] SET_C = 8'(SETTLE);
  localparam logic [7:0] FULL  = 8'((1 << NDIG) - 1);

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic        sample;
  logic        ill_q;

  logic [7:0]  nz;
  logic        one_hot;
  logic        illegal;
  logic [2:0]  sel_idx;

  logic [6:0]  lit;
  logic [3:0]  nib;
  logic        blank;
  logic        bad;

  logic [31:0] sh_dig, sh_dig_n;
  logic [7:0]  sh_dp, sh_dp_n;
  logic [7:0]  sh_bl, sh_bl_n;
  logic [7:0]  seen, seen_n;
  logic        done;

  assign nz      = ~an;
  assign one_hot = (nz != 8'd0) && ((nz & (nz - 8'd1)) == 8'd0);
  assign illegal = (nz != 8'd0) && !one_hot;

  // Index of the selected digit (valid only when one_hot).
  always_comb begin
    sel_idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (nz[i]) sel_idx = 3'(i);
  end

  // Segment pattern to BCD; blank and undecodable both give F.
  always_comb begin
    lit = ~dec_ddp[7:1];
    unique case (lit)
      7'h7E:   nib = 4'd0;
      7'h30:   nib = 4'd1;
      7'h6D:   nib = 4'd2;
      7'h79:   nib = 4'd3;
      7'h33:   nib = 4'd4;
      7'h5B:   nib = 4'd5;
      7'h5F:   nib = 4'd6;
      7'h70:   nib = 4'd7;
      7'h7F:   nib = 4'd8;
      7'h7B:   nib = 4'd9;
      default: nib = 4'hF;
    endcase
    blank = (lit == 7'd0);
    bad   = (nib == 4'hF) && !blank;
  end

  // Anode settle tracker: next state, stable count and sample strobe.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sample  = 1'b0;
    unique case (state)
      S_WAIT: begin
        if (one_hot) begin
          cnt_n   = 8'd1;
          idx_n   = sel_idx;
          state_n = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (one_hot && sel_idx == idx) begin
          if (cnt + 8'd1 >= SET_C) begin
            cnt_n   = SET_C;
            sample  = 1'b1;
            state_n = S_HOLD;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end else if (one_hot) begin
          cnt_n = 8'd1;
          idx_n = sel_idx;
        end else begin
          cnt_n   = 8'd0;
          state_n = S_WAIT;
        end
      end
      S_HOLD: begin
        if (one_hot && sel_idx == idx) begin
          state_n = S_HOLD;
        end else if (one_hot) begin
          cnt_n   = 8'd1;
          idx_n   = sel_idx;
          state_n = S_SETTLE;
        end else begin
          cnt_n   = 8'd0;
          state_n = S_WAIT;
        end
      end
      default: begin
        cnt_n   = 8'd0;
        state_n = S_WAIT;
      end
    endcase
  end

  // Shadow frame update and completion detect.
  always_comb begin
    sh_dig_n = sh_dig;
    sh_dp_n  = sh_dp;
    sh_bl_n  = sh_bl;
    seen_n   = seen;
    if (sample) begin
      sh_dig_n[4*idx +: 4] = nib;
      sh_dp_n[idx]         = ~dec_ddp[0];
      sh_bl_n[idx]         = blank;
      seen_n               = (seen | (8'd1 << idx)) & FULL;
    end
    done = sample && (seen_n == FULL);
  end

  // Tracker registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_WAIT;
      cnt   <= 8'd0;
      idx   <= 3'd0;
      ill_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      ill_q <= illegal;
    end
  end

  // Shadow registers; seen clears as the frame is published.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_dig <= 32'd0;
      sh_dp  <= 8'd0;
      sh_bl  <= 8'd0;
      seen   <= 8'd0;
    end else begin
      sh_dig <= sh_dig_n;
      sh_dp  <= sh_dp_n;
      sh_bl  <= sh_bl_n;
      seen   <= done ? 8'd0 : seen_n;
    end
  end

  // Published frame and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits      <= 32'd0;
      dp_mask     <= 8'd0;
      blank_mask  <= 8'd0;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      an_err      <= 1'b0;
    end else begin
      if (done) begin
        digits     <= sh_dig_n;
        dp_mask    <= sh_dp_n;
        blank_mask <= sh_bl_n;
      end
      frame_valid <= done;
      seg_err     <= sample && bad;
      an_err      <= illegal && !ill_q;
    end
  end

endmodule

// File: tb/tb_disp_capture.sv
// tb_disp_capture: directed scans of the display bus with a frame
// scoreboard and a monitor that checks every frame_valid.
module tb_disp_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  an = 8'hFF;
  logic [7:0]  dec_ddp = 8'hFF;
  logic [31:0] digits;
  logic [7:0]  dp_mask;
  logic [7:0]  blank_mask;
  logic        frame_valid;
  logic        seg_err;
  logic        an_err;

  disp_capture #(.SETTLE(4), .NDIG(8)) dut (
    .clk(clk),
    .rst(rst),
    .an(an),
    .dec_ddp(dec_ddp),
    .digits(digits),
    .dp_mask(dp_mask),
    .blank_mask(blank_mask),
    .frame_valid(frame_valid),
    .seg_err(seg_err),
    .an_err(an_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  dp;
    logic [7:0]  bl;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int fails = 0;
  int frames = 0;
  int seg_cnt = 0;
  int an_cnt = 0;

  // 10 = blank, 11 = segments abcd lit (not a digit)
  function automatic logic [7:0] pat(int v, bit dp);
    logic [6:0] l;
    case (v)
      0: l = 7'h7E;
      1: l = 7'h30;
      2: l = 7'h6D;
      3: l = 7'h79;
      4: l = 7'h33;
      5: l = 7'h5B;
      6: l = 7'h5F;
      7: l = 7'h70;
      8: l = 7'h7F;
      9: l = 7'h7B;
      11: l = 7'h78;
      default: l = 7'h00;
    endcase
    return {~l, ~dp};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic [7:0] a, logic [7:0] s, int n);
    @(negedge clk);
    an = a;
    dec_ddp = s;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic show(int i, logic [7:0] s, int n);
    drive(~(8'd1 << i), s, n);
  endtask

  task automatic push(logic [31:0] d, logic [7:0] dp, logic [7:0] bl);
    frame_t f;
    f.d = d;
    f.dp = dp;
    f.bl = bl;
    exp_q.push_back(f);
  endtask

  // Monitor: pops expected frames, counts error pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid) begin
        frames++;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_frame: got %h expected none", digits);
        end else begin
          frame_t f;
          f = exp_q.pop_front();
          check("frame_digits", digits, f.d);
          check("frame_dp", 32'(dp_mask), 32'(f.dp));
          check("frame_blank", 32'(blank_mask), 32'(f.bl));
        end
      end
      if (seg_err) seg_cnt++;
      if (an_err) an_cnt++;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_digits", digits, 32'h0);
    check("rst_dp", 32'(dp_mask), 32'h0);
    check("rst_blank", 32'(blank_mask), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);
    check("rst_seg_err", 32'(seg_err), 32'h0);
    check("rst_an_err", 32'(an_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // full scan, dp on digit 2
    push(32'h87654321, 8'h04, 8'h00);
    for (int i = 0; i < 8; i++) show(i, pat(i + 1, i == 2), 10);
    drive(8'hFF, 8'hFF, 4);
    #1;
    check("scan_frames", 32'(frames), 32'd1);
    check("scan_seg_err", 32'(seg_cnt), 32'd0);
    check("scan_an_err", 32'(an_cnt), 32'd0);

    // 3-cycle holds never settle
    for (int i = 0; i < 8; i++) show(i, pat(i, 0), 3);
    drive(8'hFF, 8'hFF, 4);
    #1;
    check("short_frames", 32'(frames), 32'd1);
    check("short_hold_digits", digits, 32'h87654321);
    check("short_errs", 32'(seg_cnt + an_cnt), 32'd0);

    // illegal anodes mid-scan
    push(32'h65432109, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) show(i, pat((i + 9) % 10, 0), 10);
    drive(8'hFC, pat(5, 0), 2);
    for (int i = 4; i < 8; i++) show(i, pat((i + 9) % 10, 0), 10);
    drive(8'hFF, 8'hFF, 4);
    #1;
    check("illegal_frames", 32'(frames), 32'd2);
    check("illegal_an_err", 32'(an_cnt), 32'd1);

    // bad pattern on 5, blank with dp on 7
    push(32'hF6F43210, 8'h80, 8'h80);
    for (int i = 0; i < 8; i++) begin
      if (i == 5) show(i, pat(11, 0), 10);
      else if (i == 7) show(i, pat(10, 1), 10);
      else show(i, pat(i, 0), 10);
    end
    drive(8'hFF, 8'hFF, 4);
    #1;
    check("bad_frames", 32'(frames), 32'd3);
    check("bad_seg_err", 32'(seg_cnt), 32'd1);
    check("bad_pattern_0f", 32'(pat(11, 0)), 32'h0F);

    // re-sampled digit 0 overwrites
    push(32'h88881117, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) show(i, pat(1, 0), 10);
    show(0, pat(7, 0), 10);
    for (int i = 4; i < 8; i++) show(i, pat(8, 0), 10);
    drive(8'hFF, 8'hFF, 4);
    #1;
    check("over_frames", 32'(frames), 32'd4);

    // reset mid-frame discards partial capture
    for (int i = 0; i < 5; i++) show(i, pat(9, 0), 10);
    @(negedge clk);
    #2;
    rst = 1'b1;
    an = 8'hFF;
    dec_ddp = 8'hFF;
    #1;
    check("mid_rst_digits", digits, 32'h0);
    check("mid_rst_dp", 32'(dp_mask), 32'h0);
    check("mid_rst_blank", 32'(blank_mask), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 5; i < 8; i++) show(i, pat(i, 0), 10);
    drive(8'hFF, 8'hFF, 4);
    #1;
    check("post_rst_partial", 32'(frames), 32'd4);
    push(32'h76543210, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) show(i, pat(i, 0), 10);
    drive(8'hFF, 8'hFF, 6);
    #1;
    check("post_rst_frames", 32'(frames), 32'd5);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_seg_err", 32'(seg_cnt), 32'd1);
    check("final_an_err", 32'(an_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
